acc_step_ctrl: RTL and testbench
================================

# acc_step_ctrl

Decision-filter and gear-shift controller directly upstream of the 16-bit accumulator. Takes a stream of bang-bang comparator decisions and majority-votes them over a fixed window. Emits single-cycle `enable`/`up`/`step` update commands to the accumulator, halving the step on each direction reversal until lock. Also sequences external presets through the accumulator's `ext_val`/`sel_ext` path.

## Interface
Parameters:
- `WIN`, 16: valid decisions per vote window; power of two, 4..256
- `THR`, 4: minimum |tally| that produces an update; 1..WIN
- `STEP_MAX`, 8: initial and post-preset step; 1..15
- `STEP_MIN`, 1: floor for step halving; 1..STEP_MAX
- `LOCK_CNT`, 4: reversals at `STEP_MIN` needed to declare lock; 1..15

Ports:
- `clk` in 1: clock
- `rstb` in 1: reset, asynchronous, active-low
- `loop_en` in 1: tracking enable
- `dec_valid` in 1: qualifies `dec_up` this cycle
- `dec_up` in 1: comparator decision; 1 = increase, 0 = decrease
- `preset_req` in 1: request to load `preset_val`, sampled every cycle
- `preset_val` in 16: value to load
- `enable` out 1: accumulator update strobe, one cycle wide
- `up` out 1: direction for the accumulator
- `step` out 4: step magnitude for the accumulator
- `sel_ext` out 1: select external load
- `ext_val` out 16: external load value
- `lock` out 1: loop locked

## Operation
- All outputs are registered. Reset values:
  - `enable` 0, `up` 0, `sel_ext` 0, `lock` 0
  - `step` STEP_MAX, `ext_val` 16'h8000 (mid code)
  - internal: state IDLE, tally 0, window count 0, reversal count 0, last direction 0
- States:
  - IDLE: `loop_en`=0. Tally and window count held at 0. `step` and `lock` retained.
  - TRACK: entered from IDLE when `loop_en`=1.
  - PRESET: one cycle, entered from any state when `preset_req`=1.
- Tally:
  - Signed, width $clog2(WIN)+2.
  - Each `dec_valid` cycle in TRACK adds +1 (`dec_up`=1) or -1 (`dec_up`=0) and increments the window count.
- Window end (WIN-th valid decision):
  - tally >= THR: update with up=1.
  - tally <= -THR: update with up=0.
  - Otherwise no update.
  - In every case, tally and window count clear.
- Update:
  - `enable`=1 for one cycle, with `up` and current `step`.
  - If this is not the first update since reset/preset and the direction differs from the last update, it is a reversal. A reversal sets `step` <= max(step>>1, STEP_MIN), applied after the strobe.
  - Reversal at `step`==STEP_MIN increments the reversal count, saturating at LOCK_CNT. Reaching LOCK_CNT sets `lock`=1.
  - Same-direction update: reversal count unchanged.
- PRESET:
  - Capture `preset_val` into `ext_val`.
  - Assert `enable`=1 and `sel_ext`=1 for exactly one cycle.
  - Restore `step`=STEP_MAX; clear `lock`, tally, window count and reversal count; mark next update as first.
  - Next state: TRACK if `loop_en`, else IDLE.
- `ext_val` holds its last value. `sel_ext`=0 whenever `enable` is not a preset strobe.
- `loop_en` falling in TRACK: go to IDLE next cycle; the partial window is discarded.

## Timing
- Window-closing `dec_valid` at cycle N: `enable` high in cycle N+1, `step`/`up` valid in N+1, new `step` visible in N+2.
- `preset_req` at cycle N: `enable`=`sel_ext`=1 with `ext_val`=`preset_val`(N) in cycle N+1.
- Minimum spacing between track strobes is WIN cycles.
- Simultaneous events:
  - `preset_req` with window close: preset wins and the decision is discarded.
  - `preset_req` held high: repeated PRESET cycles, each a fresh strobe.
- `loop_en` and `dec_valid` in the same cycle as IDLE→TRACK: the decision is ignored. Counting starts the following cycle.
- `rstb` asserted mid-window or during PRESET: immediate return to reset values, no strobe.
- Tally cannot overflow: |tally| <= WIN.

## Structure
- Shared package:
  - state enum {IDLE, TRACK, PRESET}
  - `ACC_MID_CODE` = 16'h8000
  - default parameter constants
  - 4-bit step type (shared with the accumulator)
- Sub-module `vote_tally`: signed up/down tally plus window counter, with `clr` input and `win_done`/`tally` outputs.
- The top level holds the FSM, gear-shift and lock logic.

## Test plan
- Reset: all outputs at reset values, `ext_val`=16'h8000, `step`=8, no strobe for 20 cycles with `loop_en`=0.
- 16 consecutive `dec_up`=1 (default params) → exactly one `enable`, `up`=1, `step`=8, one cycle after the 16th decision.
- Alternating 9-up/7-down windows (tally +2 < THR) → no strobe over 4 windows.
- Windows alternately all-up and all-down:
  - `step` sequence 8, 4, 2, 1, 1...
  - `lock`=1 after the 4th reversal at step 1
- `preset_req` with `preset_val`=16'h1234 on the window-closing cycle → single strobe with `sel_ext`=1, `ext_val`=16'h1234; no track strobe; `step`=8, `lock`=0.
- `rstb` low mid-window (tally 10), released → the next window needs a full 16 decisions before any strobe.

Source files
------------

// File: rtl/acc_step_ctrl_pkg.sv
// rtl/acc_step_ctrl_pkg.sv - shared types and constants for the accumulator step controller
// Contents: controller state enum, accumulator mid code, default parameters,
// and the 4-bit step type that the accumulator also uses.
package acc_step_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    PRESET = 2'd2
  } state_t;

  typedef logic [3:0] step_t;

  localparam logic [15:0] ACC_MID_CODE = 16'h8000;

  localparam int WIN_DEF      = 16;
  localparam int THR_DEF      = 4;
  localparam int STEP_MAX_DEF = 8;
  localparam int STEP_MIN_DEF = 1;
  localparam int LOCK_CNT_DEF = 4;

endpackage

// File: rtl/acc_step_ctrl_vote_tally.sv
// rtl/acc_step_ctrl_vote_tally.sv - signed decision tally with fixed-length vote window
// Ports:
//   clk, rstb   : clock, asynchronous active-low reset
//   clr         : discard the partial window (tally and count to 0)
//   count_en    : a qualified decision is present this cycle
//   dec_up      : decision direction, 1 = +1, 0 = -1
//   tally       : running tally including this cycle's decision
//   win_done    : this cycle's decision is the last one of the window
module vote_tally #(
  parameter int WIN = 16,
  parameter int TW  = $clog2(WIN) + 2
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 clr,
  input  logic                 count_en,
  input  logic                 dec_up,
  output logic signed [TW-1:0] tally,
  output logic                 win_done
);

  localparam int CW = $clog2(WIN);
  localparam logic signed [TW-1:0] ONE = 1;

  logic [CW-1:0]        cnt;
  logic signed [TW-1:0] acc;

  assign tally    = count_en ? (dec_up ? acc + ONE : acc - ONE) : acc;
  assign win_done = count_en && (cnt == CW'(WIN - 1));

  // The window always restarts after its last decision, whether or not it
  // produced an update.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      acc <= '0;
      cnt <= '0;
    end else if (clr || win_done) begin
      acc <= '0;
      cnt <= '0;
    end else if (count_en) begin
      acc <= tally;
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/acc_step_ctrl.sv
// rtl/acc_step_ctrl.sv - majority-vote filter and gear-shift controller feeding the accumulator
// Ports:
//   clk, rstb             : clock, asynchronous active-low reset
//   loop_en               : tracking enable
//   dec_valid, dec_up     : qualified bang-bang decision
//   preset_req, preset_val: external preset request and value
//   enable, up, step      : one-cycle accumulator update command
//   sel_ext, ext_val      : external load select and value
//   lock                  : loop locked
module acc_step_ctrl
  import acc_step_ctrl_pkg::*;
#(
  parameter int WIN      = WIN_DEF,
  parameter int THR      = THR_DEF,
  parameter int STEP_MAX = STEP_MAX_DEF,
  parameter int STEP_MIN = STEP_MIN_DEF,
  parameter int LOCK_CNT = LOCK_CNT_DEF
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        loop_en,
  input  logic        dec_valid,
  input  logic        dec_up,
  input  logic        preset_req,
  input  logic [15:0] preset_val,
  output logic        enable,
  output logic        up,
  output step_t       step,
  output logic        sel_ext,
  output logic [15:0] ext_val,
  output logic        lock
);

  localparam int TW = $clog2(WIN) + 2;
  localparam logic signed [TW-1:0] THR_S = TW'(THR);
  localparam step_t STEP_MAX4 = 4'(STEP_MAX);
  localparam step_t STEP_MIN4 = 4'(STEP_MIN);
  localparam logic [3:0] LOCK4 = 4'(LOCK_CNT);

  state_t state, state_nx;

  logic signed [TW-1:0] tally;
  logic                 win_done, count_en, clr;

  // have_dir = an update has happened since reset/preset; shift_pend delays
  // the step halving by one cycle so the strobe carries the pre-reversal step.
  logic       have_dir, last_dir, shift_pend;
  logic [3:0] rev_cnt;

  logic        upd, upd_dir, is_rev;
  step_t       step_half;
  logic        enable_nx, up_nx, sel_ext_nx, lock_nx;
  logic        have_dir_nx, last_dir_nx, shift_pend_nx;
  logic [3:0]  rev_cnt_nx;
  logic [15:0] ext_val_nx;
  step_t       step_nx;

  // Decisions count only while already in TRACK with loop_en still high;
  // a preset discards the decision and the partial window.
  assign count_en = (state == TRACK) && loop_en && dec_valid && !preset_req;
  assign clr      = (state != TRACK) || !loop_en || preset_req;

  vote_tally #(.WIN(WIN), .TW(TW)) u_vote_tally (
    .clk      (clk),
    .rstb     (rstb),
    .clr      (clr),
    .count_en (count_en),
    .dec_up   (dec_up),
    .tally    (tally),
    .win_done (win_done)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (preset_req) begin
      state_nx = PRESET;
    end else begin
      case (state)
        IDLE:    if (loop_en) state_nx = TRACK;
        TRACK:   if (!loop_en) state_nx = IDLE;
        PRESET:  state_nx = loop_en ? TRACK : IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    upd     = 1'b0;
    upd_dir = 1'b0;
    if (win_done) begin
      if (tally >= THR_S) begin
        upd     = 1'b1;
        upd_dir = 1'b1;
      end else if (tally <= -THR_S) begin
        upd = 1'b1;
      end
    end
    is_rev    = upd && have_dir && (upd_dir != last_dir);
    step_half = ((step >> 1) < STEP_MIN4) ? STEP_MIN4 : (step >> 1);
  end

  always_comb begin
    enable_nx     = 1'b0;
    sel_ext_nx    = 1'b0;
    up_nx         = up;
    ext_val_nx    = ext_val;
    step_nx       = step;
    lock_nx       = lock;
    rev_cnt_nx    = rev_cnt;
    have_dir_nx   = have_dir;
    last_dir_nx   = last_dir;
    shift_pend_nx = 1'b0;
    if (preset_req) begin
      enable_nx   = 1'b1;
      sel_ext_nx  = 1'b1;
      ext_val_nx  = preset_val;
      step_nx     = STEP_MAX4;
      lock_nx     = 1'b0;
      rev_cnt_nx  = '0;
      have_dir_nx = 1'b0;
    end else begin
      if (shift_pend) step_nx = step_half;
      if (upd) begin
        enable_nx     = 1'b1;
        up_nx         = upd_dir;
        have_dir_nx   = 1'b1;
        last_dir_nx   = upd_dir;
        shift_pend_nx = is_rev;
        if (is_rev && (step == STEP_MIN4) && (rev_cnt != LOCK4)) begin
          rev_cnt_nx = rev_cnt + 4'd1;
          if (rev_cnt + 4'd1 == LOCK4) lock_nx = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      enable     <= 1'b0;
      up         <= 1'b0;
      sel_ext    <= 1'b0;
      lock       <= 1'b0;
      step       <= STEP_MAX4;
      ext_val    <= ACC_MID_CODE;
      rev_cnt    <= '0;
      have_dir   <= 1'b0;
      last_dir   <= 1'b0;
      shift_pend <= 1'b0;
    end else begin
      enable     <= enable_nx;
      up         <= up_nx;
      sel_ext    <= sel_ext_nx;
      lock       <= lock_nx;
      step       <= step_nx;
      ext_val    <= ext_val_nx;
      rev_cnt    <= rev_cnt_nx;
      have_dir   <= have_dir_nx;
      last_dir   <= last_dir_nx;
      shift_pend <= shift_pend_nx;
    end
  end

endmodule

// File: tb/tb_acc_step_ctrl.sv
// tb/tb_acc_step_ctrl.sv - self-checking bench for acc_step_ctrl with a behavioural reference model
module tb_acc_step_ctrl;
  import acc_step_ctrl_pkg::*;

  localparam int WIN  = 16;
  localparam int THR  = 4;
  localparam int SMAX = 8;
  localparam int SMIN = 1;
  localparam int LCNT = 4;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        loop_en = 1'b0, dec_valid = 1'b0, dec_up = 1'b0, preset_req = 1'b0;
  logic [15:0] preset_val = '0;
  logic        enable, up, sel_ext, lock;
  step_t       step;
  logic [15:0] ext_val;

  always #5 clk = ~clk;

  acc_step_ctrl #(.WIN(WIN), .THR(THR), .STEP_MAX(SMAX), .STEP_MIN(SMIN), .LOCK_CNT(LCNT)) dut (
    .clk(clk), .rstb(rstb), .loop_en(loop_en), .dec_valid(dec_valid), .dec_up(dec_up),
    .preset_req(preset_req), .preset_val(preset_val), .enable(enable), .up(up),
    .step(step), .sel_ext(sel_ext), .ext_val(ext_val), .lock(lock)
  );

  int n_checks = 0;
  int n_errors = 0;
  int strobes  = 0;

  // Reference model: window as an integer sum and count, step as an integer.
  int          m_sum, m_n, m_step, m_rev;
  bit          m_first, m_last, m_pend, m_counting, m_lock, m_en, m_up, m_sel;
  logic [15:0] m_ext;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_sum = 0; m_n = 0; m_step = SMAX; m_rev = 0;
    m_first = 1; m_last = 0; m_pend = 0; m_counting = 0; m_lock = 0;
    m_en = 0; m_up = 0; m_sel = 0; m_ext = 16'h8000;
  endfunction

  // Predicts the outputs after the coming clock edge from the current inputs.
  function automatic void model_cycle();
    bit upd, dir;
    m_en  = 0;
    m_sel = 0;
    if (preset_req) begin
      m_en = 1; m_sel = 1; m_ext = preset_val; m_step = SMAX; m_lock = 0; m_rev = 0;
      m_first = 1; m_pend = 0; m_sum = 0; m_n = 0; m_counting = 0;
      return;
    end
    if (m_pend) begin
      m_step = (m_step / 2 > SMIN) ? m_step / 2 : SMIN;
      m_pend = 0;
    end
    if (m_counting && loop_en) begin
      if (dec_valid) begin
        m_sum += dec_up ? 1 : -1;
        m_n++;
        if (m_n == WIN) begin
          upd = 0; dir = 0;
          if (m_sum >= THR) begin upd = 1; dir = 1; end
          else if (m_sum <= -THR) upd = 1;
          if (upd) begin
            m_en = 1; m_up = dir;
            if (!m_first && dir != m_last) begin
              m_pend = 1;
              if (m_step == SMIN && m_rev < LCNT) begin
                m_rev++;
                if (m_rev == LCNT) m_lock = 1;
              end
            end
            m_first = 0; m_last = dir;
          end
          m_sum = 0; m_n = 0;
        end
      end
    end else begin
      m_sum = 0; m_n = 0;
    end
    m_counting = loop_en;
  endfunction

  task automatic check_outputs();
    check("enable",  32'(enable),  32'(m_en));
    check("sel_ext", 32'(sel_ext), 32'(m_sel));
    check("up",      32'(up),      32'(m_up));
    check("step",    32'(step),    32'(m_step));
    check("ext_val", 32'(ext_val), 32'(m_ext));
    check("lock",    32'(lock),    32'(m_lock));
  endtask

  task automatic tick();
    model_cycle();
    @(posedge clk);
    #1;
    if (enable) strobes++;
    check_outputs();
  endtask

  task automatic drive(input bit le, input bit dv, input bit du, input bit pr, input logic [15:0] pv);
    loop_en = le; dec_valid = dv; dec_up = du; preset_req = pr; preset_val = pv;
    tick();
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    #2;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    rstb = 1'b1;
  endtask

  task automatic window(input int nup, input int ndn);
    for (int i = 0; i < nup; i++) drive(1, 1, 1, 0, 16'h0);
    for (int i = 0; i < ndn; i++) drive(1, 1, 0, 0, 16'h0);
  endtask

  initial begin
    int bias;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    check("rst_ext_val", 32'(ext_val), 32'h8000);
    check("rst_step", 32'(step), 32'd8);
    strobes = 0;
    for (int i = 0; i < 20; i++) drive(0, 1, 1, 0, 16'h0);
    check("idle_strobes", 32'(strobes), 32'd0);

    // Enter TRACK with a decision on the transition cycle: it must be ignored.
    drive(1, 1, 0, 0, 16'h0);
    strobes = 0;
    window(16, 0);
    check("first_win_en", 32'(enable), 32'd1);
    check("first_win_up", 32'(up), 32'd1);
    check("first_win_step", 32'(step), 32'd8);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 16'h0);
    check("first_win_count", 32'(strobes), 32'd1);

    strobes = 0;
    for (int w = 0; w < 4; w++) window(9, 7);
    check("weak_vote_strobes", 32'(strobes), 32'd0);

    for (int w = 0; w < 8; w++) begin
      if (w % 2 == 0) window(16, 0);
      else            window(0, 16);
    end
    drive(1, 0, 0, 0, 16'h0);
    check("gear_lock", 32'(lock), 32'd1);
    check("gear_step", 32'(step), 32'd1);

    strobes = 0;
    window(15, 0);
    drive(1, 1, 1, 1, 16'h1234);
    check("preset_sel", 32'(sel_ext), 32'd1);
    check("preset_ext", 32'(ext_val), 32'h1234);
    check("preset_step", 32'(step), 32'd8);
    check("preset_lock", 32'(lock), 32'd0);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 16'h0);
    check("preset_strobes", 32'(strobes), 32'd1);

    window(10, 0);
    do_reset();
    drive(1, 0, 0, 0, 16'h0);
    strobes = 0;
    window(15, 0);
    check("post_rst_partial", 32'(strobes), 32'd0);
    window(1, 0);
    check("post_rst_full", 32'(strobes), 32'd1);

    bias = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 48 == 0) bias = 25 * int'($urandom_range(4));
      if ($urandom_range(399) == 0) begin
        do_reset();
      end else begin
        drive(($urandom_range(63) != 0) ? 1'b1 : ~loop_en,
              $urandom_range(3) != 0,
              $urandom_range(99) < bias,
              $urandom_range(199) == 0,
              16'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
